// File: rtl/sound_frame_sequencer.sv
// APU frame sequencer: 512 Hz step divider, length/sweep/envelope tick strobes,
// and per-channel length counters with the NR52 channel-active status bits.
module sound_frame_sequencer #(
    parameter int unsigned DIV_COUNT = 64453
) (
    input  logic       I_CLK,
    input  logic       I_RESET_L,
    input  logic       I_MASTER_EN,
    input  logic [3:0] I_LEN_LOAD,
    input  logic [7:0] I_LEN_DATA,
    input  logic [3:0] I_TRIGGER,
    input  logic [3:0] I_LEN_EN,
    output logic       O_LENGTH_TICK,
    output logic       O_SWEEP_TICK,
    output logic       O_ENV_TICK,
    output logic [2:0] O_STEP,
    output logic [3:0] O_CH_ACTIVE
);
    localparam int unsigned DW = $clog2(DIV_COUNT);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

    logic          rst_sync_q;
    logic          run;
    logic          wrap;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    step_q, step_d;
    logic          len_tick_q, len_tick_d;
    logic          sweep_tick_q, sweep_tick_d;
    logic          env_tick_q, env_tick_d;
    logic [8:0]    len_q [4];
    logic [8:0]    len_d [4];
    logic [3:0]    act_q, act_d;

    // Release is synchronised so the first count lands on the 2nd edge.
    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign run  = rst_sync_q & I_MASTER_EN;
    assign wrap = run && (div_q == DIV_LAST);

    always_comb begin
        div_d        = '0;
        step_d       = '0;
        len_tick_d   = 1'b0;
        sweep_tick_d = 1'b0;
        env_tick_d   = 1'b0;
        act_d        = '0;
        for (int n = 0; n < 4; n++) begin
            len_d[n] = '0;
        end
        if (run) begin
            div_d        = wrap ? '0 : div_q + DW'(1);
            step_d       = wrap ? step_q + 3'd1 : step_q;
            len_tick_d   = wrap && !step_q[0];
            sweep_tick_d = wrap && (step_q[1:0] == 2'b10);
            env_tick_d   = wrap && (step_q == 3'd7);
            act_d        = act_q;
            for (int n = 0; n < 4; n++) begin
                len_d[n] = len_q[n];
                if (I_LEN_LOAD[n]) begin
                    // Loaded value is non-zero, so a same-cycle trigger never reloads.
                    len_d[n] = (n == 2) ? 9'd256 - {1'b0, I_LEN_DATA}
                                        : 9'd64 - {3'b000, I_LEN_DATA[5:0]};
                    if (I_TRIGGER[n]) begin
                        act_d[n] = 1'b1;
                    end
                end else if (I_TRIGGER[n]) begin
                    act_d[n] = 1'b1;
                    if (len_q[n] == 9'd0) begin
                        len_d[n] = (n == 2) ? 9'd256 : 9'd64;
                    end
                end else if (len_tick_q && I_LEN_EN[n] && (len_q[n] != 9'd0)) begin
                    len_d[n] = len_q[n] - 9'd1;
                    if (len_q[n] == 9'd1) begin
                        act_d[n] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            div_q        <= '0;
            step_q       <= '0;
            len_tick_q   <= 1'b0;
            sweep_tick_q <= 1'b0;
            env_tick_q   <= 1'b0;
            act_q        <= '0;
            for (int n = 0; n < 4; n++) begin
                len_q[n] <= '0;
            end
        end else begin
            div_q        <= div_d;
            step_q       <= step_d;
            len_tick_q   <= len_tick_d;
            sweep_tick_q <= sweep_tick_d;
            env_tick_q   <= env_tick_d;
            act_q        <= act_d;
            for (int n = 0; n < 4; n++) begin
                len_q[n] <= len_d[n];
            end
        end
    end

    assign O_LENGTH_TICK = len_tick_q;
    assign O_SWEEP_TICK  = sweep_tick_q;
    assign O_ENV_TICK    = env_tick_q;
    assign O_STEP        = step_q;
    assign O_CH_ACTIVE   = act_q;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with DIV_COUNT=4.
// Cadence, length expiry, collisions, power-off and async reset.
module tb_sound_frame_sequencer;
    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] load = '0;
    logic [3:0] trig = '0;
    logic [3:0] len_en = '0;
    logic [7:0] data = '0;
    logic       ltick, stick, etick;
    logic [2:0] step;
    logic [3:0] act;

    int n_chk = 0;
    int n_err = 0;

    sound_frame_sequencer #(.DIV_COUNT(DIV)) dut (
        .I_CLK        (clk),
        .I_RESET_L    (rst_n),
        .I_MASTER_EN  (en),
        .I_LEN_LOAD   (load),
        .I_LEN_DATA   (data),
        .I_TRIGGER    (trig),
        .I_LEN_EN     (len_en),
        .O_LENGTH_TICK(ltick),
        .O_SWEEP_TICK (stick),
        .O_ENV_TICK   (etick),
        .O_STEP       (step),
        .O_CH_ACTIVE  (act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] l, input logic [3:0] t,
                         input logic [7:0] d);
        load = l;
        trig = t;
        data = d;
        cyc();
        load = '0;
        trig = '0;
    endtask

    task automatic wait_ltick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = ltick;
        end
        if (!seen) check("ltick_timeout", 0, 1);
    endtask

    // Expected {len,sweep,env,step} after edge k following reset release.
    function automatic logic [5:0] exp_cad(input int k);
        int s;
        logic [2:0] nx;
        logic lt, sw, ev;
        lt = 1'b0;
        sw = 1'b0;
        ev = 1'b0;
        nx = 3'd0;
        if (k >= 5) begin
            s  = ((k - 5) / 4) % 8;
            nx = 3'((s + 1) % 8);
            if ((k - 5) % 4 == 0) begin
                lt = (s % 2 == 0);
                sw = (s == 2 || s == 6);
                ev = (s == 7);
            end
        end
        return {lt, sw, ev, nx};
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit found;
        repeat (3) cyc();
        check("reset", {ltick, stick, etick, step, act}, 0);
        rst_n = 1'b1;

        for (int k = 1; k <= 64; k++) begin
            cyc();
            check("cadence", {ltick, stick, etick, step}, exp_cad(k));
        end

        // Channel 1: length 2
        wait_ltick();
        cyc();
        len_en[0] = 1'b1;
        drive(4'b0001, 4'b0000, 8'd62);
        check("ch1_idle", act[0], 0);
        drive(4'b0000, 4'b0001, 8'd0);
        check("ch1_trig", act[0], 1);
        wait_ltick();
        check("ch1_t1", act[0], 1);
        cyc();
        check("ch1_after1", act[0], 1);
        wait_ltick();
        check("ch1_t2", act[0], 1);
        cyc();
        check("ch1_expire", act[0], 0);

        // Channel 3: full 256
        wait_ltick();
        cyc();
        len_en[2] = 1'b1;
        drive(4'b0100, 4'b0000, 8'd0);
        drive(4'b0000, 4'b0100, 8'd0);
        check("ch3_trig", act[2], 1);
        for (int i = 1; i <= 256; i++) begin
            wait_ltick();
            cyc();
            check("ch3_len", act[2], (i < 256) ? 1 : 0);
        end
        len_en[2] = 1'b0;
        drive(4'b0000, 4'b0100, 8'd0);
        check("ch3_retrig", act[2], 1);
        for (int i = 1; i <= 300; i++) wait_ltick();
        cyc();
        check("ch3_hold", act[2], 1);

        // Channel 4: trigger at zero count reloads 64
        wait_ltick();
        cyc();
        len_en[3] = 1'b1;
        drive(4'b1000, 4'b1000, 8'd63);
        check("ch4_lt", act[3], 1);
        wait_ltick();
        cyc();
        check("ch4_expire", act[3], 0);
        drive(4'b0000, 4'b1000, 8'd0);
        check("ch4_retrig", act[3], 1);
        for (int i = 1; i <= 64; i++) begin
            wait_ltick();
            cyc();
            check("ch4_len", act[3], (i < 64) ? 1 : 0);
        end

        // Channel 2: trigger in the tick cycle skips the decrement
        len_en[1] = 1'b1;
        drive(4'b0010, 4'b0000, 8'd61);
        drive(4'b0000, 4'b0010, 8'd0);
        check("ch2_trig", act[1], 1);
        wait_ltick();
        drive(4'b0000, 4'b0010, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            wait_ltick();
            cyc();
            check("ch2_coll", act[1], (i < 3) ? 1 : 0);
        end
        drive(4'b0010, 4'b0010, 8'd63);
        check("ch2_lt_act", act[1], 1);
        wait_ltick();
        cyc();
        check("ch2_lt_exp", act[1], 0);

        // Power off at step 5
        len_en = '0;
        drive(4'b0000, 4'b0001, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (step == 3'd5) found = 1'b1;
            else cyc();
        end
        check("step5_seen", found, 1);
        check("pre_off_act", act, 4'b0101);
        en = 1'b0;
        cyc();
        check("pwr_off", {ltick, stick, etick, step, act}, 0);
        drive(4'b1111, 4'b1111, 8'd63);
        check("pwr_trig_ign", act, 0);
        repeat (3) cyc();
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("reen_quiet", {ltick, step}, 0);
        end
        cyc();
        check("reen_tick", {ltick, stick, etick, step}, {3'b100, 3'd1});
        check("reen_act", act, 0);
        cyc();
        len_en[0] = 1'b1;
        drive(4'b0000, 4'b0001, 8'd0);
        check("reen_trig", act[0], 1);
        wait_ltick();
        cyc();
        check("pwr_load_ign", act[0], 1);

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {ltick, stick, etick, step, act}, 0);
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            check("post_rst", {ltick, step}, (e == 5) ? {1'b1, 3'd1} : 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sound_frame_sequencer.md
# sound_frame_sequencer

Central timing controller for the APU. It divides the system clock down to the 512 Hz frame-sequencer rate and steps an 8-phase sequence. From that sequence it issues single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) tick strobes to the four sound channels. It also owns the per-channel length counters and the channel-active status bits that NR52 reads back, so individual channels no longer free-run their own large timing counters.

## Interface
- DIV_COUNT, default 64453: I_CLK cycles per frame-sequencer step (33 MHz / 512); must be >= 2.
- I_CLK  input  1  system clock; all state changes on its rising edge.
- I_RESET_L  input  1  reset, asynchronous, active-low.
- I_MASTER_EN  input  1  NR52 bit 7; 0 = APU powered off.
- I_LEN_LOAD  input  4  per-channel strobe, one cycle: load length from I_LEN_DATA (bit n = channel n+1).
- I_LEN_DATA  input  8  NRx1 length field; channels 1, 2 and 4 use bits [5:0], channel 3 uses [7:0].
- I_TRIGGER  input  4  per-channel one-cycle restart strobe (NRx4 bit 7 write).
- I_LEN_EN  input  4  per-channel length-enable level (NRx4 bit 6).
- O_LENGTH_TICK  output  1  one-cycle pulse on steps 0, 2, 4, 6.
- O_SWEEP_TICK  output  1  one-cycle pulse on steps 2, 6.
- O_ENV_TICK  output  1  one-cycle pulse on step 7.
- O_STEP  output  3  step that will execute on the next wrap.
- O_CH_ACTIVE  output  4  channel-active status, NR52 bits [3:0].

## Operation
- Divider: counts 0..DIV_COUNT-1 while I_MASTER_EN=1. When it reaches DIV_COUNT-1 it wraps to 0; this is the "wrap cycle".
- Step counter: 3 bits, holds the next step s. On the wrap cycle, s is executed and the counter becomes s+1 mod 8 (7 -> 0).
- Tick outputs are registered from the decode of executed step s and are high for exactly the one cycle after the wrap edge.
- Length counter per channel is 9 bits. Max is 64 for channels 1, 2, 4 and 256 for channel 3.
- Length-counter rules, in descending priority per channel per cycle:
  1. I_LEN_LOAD[n]: counter <= max - data. Channels 1, 2, 4 use data[5:0], giving 1..64. Channel 3 uses data[7:0], giving 1..256. Active is unchanged.
  2. I_TRIGGER[n]: active[n] <= 1. If counter == 0, counter <= max.
  3. O_LENGTH_TICK high, I_LEN_EN[n]=1 and counter != 0: counter decrements by 1. If the result is 0, active[n] <= 0 in the same edge.
- A load in the same cycle as a trigger: the load is applied first, then the trigger sets active. The counter is not reloaded, because it is now non-zero. No decrement happens that cycle.
- A tick in the same cycle as a trigger or load: that channel's decrement is skipped for that cycle.
- Counter == 0 with I_LEN_EN=0: nothing happens. The channel stays active until triggered or powered off.
- Master disable (I_MASTER_EN=0): divider, step, all ticks, counters and O_CH_ACTIVE are forced to 0 synchronously. I_LEN_LOAD and I_TRIGGER are ignored.
- Master re-enable: divider restarts at 0 and step at 0. The first tick fires DIV_COUNT cycles later (step 0 -> O_LENGTH_TICK).

## Timing
- Reset (I_RESET_L=0, asynchronous): divider=0, step=0, O_STEP=0, all ticks=0, all counters=0, O_CH_ACTIVE=0.
- Reset deassertion is synchronised internally; the first divider increment occurs on the 2nd rising I_CLK after release.
- Reset asserted mid-count: all state clears immediately, without waiting for a clock edge.
- Tick period in steady state:
  - O_LENGTH_TICK: every 2*DIV_COUNT cycles.
  - O_SWEEP_TICK: every 4*DIV_COUNT cycles.
  - O_ENV_TICK: every 8*DIV_COUNT cycles.
  - Each tick is exactly 1 cycle wide, never back-to-back.
- O_STEP updates on the wrap edge, coincident with the tick rising.
- Latency:
  - I_TRIGGER -> O_CH_ACTIVE high: 1 cycle.
  - Final decrement -> O_CH_ACTIVE low: same edge as the counter reaching 0, i.e. the edge ending the tick cycle.
  - I_LEN_LOAD -> counter updated: 1 cycle.
- No handshakes; all strobes are single-cycle, level-insensitive beyond the sampled edge.

## Test plan
- Step and tick cadence: DIV_COUNT=4, enable, run 64 cycles.
  - O_LENGTH_TICK pulses at cycles 5, 13, 21, 29, … (every 8).
  - O_SWEEP_TICK at 13, 29 (every 16).
  - O_ENV_TICK at 33 (every 32).
  - O_STEP sequence 0..7 wraps to 0.
- Length expiry, channel 1: load data=62 (length 2), trigger, I_LEN_EN=1.
  - O_CH_ACTIVE[0]=1 one cycle after trigger.
  - Drops to 0 on the edge ending the 2nd O_LENGTH_TICK.
- Channel 3 full length: data=0, trigger, I_LEN_EN=1.
  - Active for exactly 256 length ticks.
  - With I_LEN_EN=0, still active after 300 ticks.
- Trigger at zero count: expire channel 4, then trigger with no load.
  - Counter reloads 64; active=1.
  - Expires after 64 ticks.
- Collisions:
  - Trigger channel 2 in the exact tick cycle: counter is not decremented that cycle.
  - Load and trigger in the same cycle with data=63: active=1, counter=1, expires on the next tick.
- Power and reset:
  - Drop I_MASTER_EN mid-sequence at step 5: everything reads 0 and triggers are ignored. Re-enable: first O_LENGTH_TICK after 4 cycles, O_STEP=1.
  - Pulse I_RESET_L low between clock edges: all outputs 0 before the next edge.
